// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch stage.
// Holds the reset PC default, bus widths and the IF->ID entry layout.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

  localparam int PC_W        = 32;
  localparam int INST_W      = 32;
  localparam int BR_BUS_W    = 33;
  localparam int IF_ID_BUS_W = 64;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous flush and no fall-through path.
// Ports: clk, resetn, push, pop, flush, wdata, rdata (head), count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Storage needs no reset; only occupancy decides validity.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push) begin
      mem[tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/ifstage_fq.sv
// Fetch stage: sequential prefetch into a fetch queue, redirect on branch.
// Ports: clk, resetn, id_allowin, br_bus, IF->ID bus, inst SRAM, fq_count.
module ifstage_fq
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          FQ_DEPTH = 4,
  parameter int          CNT_W    = $clog2(FQ_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   id_allowin,
  input  logic [BR_BUS_W-1:0]    br_bus,
  output logic                   if_validout,
  output logic [IF_ID_BUS_W-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_we,
  output logic [PC_W-1:0]        inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [INST_W-1:0]      inst_sram_rdata,
  output logic [CNT_W-1:0]       fq_count
);

  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FQ_DEPTH);

  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] fetch_pc;
  logic            req_q;
  logic [PC_W-1:0] req_pc_q;
  logic            pop;
  logic            push;
  logic [CNT_W:0]  used;
  if_id_t          wentry;
  if_id_t          hentry;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign if_validout = (fq_count != '0) & ~br_taken;
  assign pop         = if_validout & id_allowin;
  assign push        = req_q & ~br_taken;

  // Credit includes the in-flight response so a push never hits a full queue.
  assign used = {1'b0, fq_count}
              + {{CNT_W{1'b0}}, req_q}
              - {{CNT_W{1'b0}}, pop};

  assign inst_sram_addr  = br_taken ? br_target : fetch_pc;
  assign inst_sram_en    = resetn & (br_taken | (used < DEPTH_V));
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (inst_sram_en) begin
      fetch_pc <= inst_sram_addr + 32'd4;
      req_q    <= 1'b1;
      req_pc_q <= inst_sram_addr;
    end else begin
      req_q <= 1'b0;
      if (br_taken) fetch_pc <= br_target;
    end
  end

  assign wentry.pc   = req_pc_q;
  assign wentry.inst = inst_sram_rdata;

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (IF_ID_BUS_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (br_taken),
    .wdata  (wentry),
    .rdata  (hentry),
    .count  (fq_count)
  );

  assign if_to_id_bus = hentry;

endmodule

// File: tb/tb_ifstage_fq.sv
// Randomised bench for ifstage_fq against a queue-level reference model.
// Drives stimulus at negedge, checks #1 later, advances the model at posedge.
module tb_ifstage_fq;
  import if_pkg::*;

  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        id_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        if_validout;
  logic [63:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic [CW-1:0] fq_count;

  always #5 clk = ~clk;

  ifstage_fq #(.RESET_PC(32'h1c000000), .FQ_DEPTH(D)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_allowin      (id_allowin),
    .br_bus          (br_bus),
    .if_validout     (if_validout),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .fq_count        (fq_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h13579bdf;
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] mq [$];
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_pc = '0;
  logic [31:0] m_fpc = 32'h1c000000;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rn, input bit al, input bit bt,
                     input logic [31:0] tg, input bit full);
    bit          ev;
    bit          ep;
    bit          een;
    int          used;
    logic [31:0] ea;
    @(negedge clk);
    resetn     = rn;
    id_allowin = al;
    br_bus     = {bt, tg};
    #1;
    ev   = (mq.size() != 0) && !bt;
    ep   = ev && al;
    used = mq.size() + int'(m_inf) - int'(ep);
    een  = rn && (bt || used < D);
    ea   = bt ? tg : m_fpc;
    chk("en", 64'(inst_sram_en), 64'(een));
    if (full) begin
      chk("valid", 64'(if_validout), 64'(ev));
      chk("addr", 64'(inst_sram_addr), 64'(ea));
      chk("count", 64'(fq_count), 64'(mq.size()));
      if (ev) begin
        chk("pc", 64'(if_to_id_bus[63:32]), 64'(mq[0]));
        chk("inst", 64'(if_to_id_bus[31:0]), 64'(inst_of(mq[0])));
      end
    end
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_inf = 1'b0;
      m_fpc = 32'h1c000000;
    end else begin
      if (bt) begin
        mq.delete();
      end else begin
        if (ep) void'(mq.pop_front());
        if (m_inf) mq.push_back(m_inf_pc);
      end
      m_inf = een;
      if (een) begin
        m_inf_pc = ea;
        m_fpc    = ea + 32'd4;
      end else if (bt) begin
        m_fpc = tg;
      end
    end
  endtask

  function automatic logic [31:0] rnd_tgt();
    return 32'h1c000000 + (32'($urandom_range(0, 1023)) << 2);
  endfunction

  initial begin
    @(posedge clk);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("we", 64'(inst_sram_we), 64'h0);
    chk("wdata", 64'(inst_sram_wdata), 64'h0);

    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++)  cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);

    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h1c000100, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 32'h1c000200, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 32'h1c000300, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'h1c000400, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);

    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
      end else begin
        cyc(1'b1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, rnd_tgt(), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
